// File: rtl/lake_spec_pkg.sv
// lake_spec_pkg: shared widths, the per-port configuration layout and the
// helpers used to decode it.
//
// Per-port configuration field (275 bits, LSB first):
//   dim [3:0], extent[d] [4+16d +: 16], sched_offset [115:100],
//   sched_stride[d] [116+16d +: 16], addr_offset [220:212],
//   addr_stride[d] [221+9d +: 9].
// The full configuration word carries the write port in [274:0] and the
// read port in [549:275].
package lake_spec_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int MEM_DEPTH      = 512;
   localparam int ADDR_WIDTH     = 9;
   localparam int MAX_DIM        = 6;
   localparam int CNT_WIDTH      = 16;
   localparam int PORT_CFG_WIDTH = 275;
   localparam int CFG_WIDTH      = 2 * PORT_CFG_WIDTH;

   // First member sits at the MSB end; element 0 of each packed array is
   // at its LSB, so this matches the field layout above bit for bit.
   typedef struct packed {
      logic [MAX_DIM-1:0][ADDR_WIDTH-1:0] addr_stride;   // [274:221]
      logic [ADDR_WIDTH-1:0]              addr_offset;   // [220:212]
      logic [MAX_DIM-1:0][CNT_WIDTH-1:0]  sched_stride;  // [211:116]
      logic [CNT_WIDTH-1:0]               sched_offset;  // [115:100]
      logic [MAX_DIM-1:0][CNT_WIDTH-1:0]  extent;        // [99:4]
      logic [3:0]                         dim;           // [3:0]
   } port_cfg_t;

   // idx 0 selects the write port, idx 1 the read port.
   function automatic port_cfg_t unpack_port_cfg(input logic [CFG_WIDTH-1:0] cfg,
                                                 input logic                 idx);
      if (idx)
         return port_cfg_t'(cfg[CFG_WIDTH-1:PORT_CFG_WIDTH]);
      return port_cfg_t'(cfg[PORT_CFG_WIDTH-1:0]);
   endfunction

   // Out-of-range loop depths are clamped to 1..MAX_DIM.
   function automatic logic [3:0] active_dims(input logic [3:0] dim);
      if (dim == 4'd0)
         return 4'd1;
      if (dim > 4'(MAX_DIM))
         return 4'(MAX_DIM);
      return dim;
   endfunction

   // Last legal iterator value; an extent of 0 behaves like an extent of 1.
   function automatic logic [CNT_WIDTH-1:0] extent_last(input logic [CNT_WIDTH-1:0] ext);
      if (ext == '0)
         return '0;
      return ext - CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/lake_spec_port_ctrl.sv
// lake_spec_port_ctrl: affine loop-nest controller for one buffer port.
// Keeps the iterator odometer and done flag, and derives the port's current
// schedule time and address from them.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   flush_i       in   synchronous restart (clears iterators and done)
//   cfg_i         in   decoded port configuration
//   cycle_count_i in   global schedule cycle counter
//   fire_o        out  port accesses memory on this edge
//   addr_o        out  memory address of the current iteration
module lake_spec_port_ctrl
   import lake_spec_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  port_cfg_t             cfg_i,
   input  logic [CNT_WIDTH-1:0]  cycle_count_i,
   output logic                  fire_o,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic [MAX_DIM-1:0][CNT_WIDTH-1:0] iter_q, iter_d;
   logic                              done_q, done_d;
   logic [CNT_WIDTH-1:0]              time_w;
   logic [CNT_WIDTH-1:0]              tprod_w;
   logic [ADDR_WIDTH-1:0]             aprod_w;
   logic [3:0]                        dims_w;
   logic                              carry_w;

   // Inactive dimensions keep their iterator at 0, so summing all MAX_DIM
   // terms is equivalent to summing only the active ones. Products are
   // truncated to the target width, which gives the mod-2^16 / mod-512 wrap.
   always_comb begin
      time_w  = cfg_i.sched_offset;
      addr_o  = cfg_i.addr_offset;
      tprod_w = '0;
      aprod_w = '0;
      for (int d = 0; d < MAX_DIM; d++) begin
         tprod_w = cfg_i.sched_stride[d] * iter_q[d];
         aprod_w = cfg_i.addr_stride[d] * iter_q[d][ADDR_WIDTH-1:0];
         time_w  = time_w + tprod_w;
         addr_o  = addr_o + aprod_w;
      end
   end

   assign fire_o = !flush_i && !done_q && (cycle_count_i == time_w);
   assign dims_w = active_dims(cfg_i.dim);

   // Odometer advance: a carry that survives past the outermost active
   // dimension means the whole nest has been visited.
   always_comb begin
      iter_d  = iter_q;
      done_d  = done_q;
      carry_w = fire_o;
      for (int d = 0; d < MAX_DIM; d++) begin
         if (carry_w && (d < int'(dims_w))) begin
            if (iter_q[d] >= extent_last(cfg_i.extent[d])) begin
               iter_d[d] = '0;
            end else begin
               iter_d[d] = iter_q[d] + CNT_WIDTH'(1);
               carry_w   = 1'b0;
            end
         end
      end
      if (carry_w)
         done_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter_q <= '0;
         done_q <= 1'b0;
      end else if (flush_i) begin
         iter_q <= '0;
         done_q <= 1'b0;
      end else begin
         iter_q <= iter_d;
         done_q <= done_d;
      end
   end

endmodule

// File: rtl/lake_spec.sv
// lake_spec: statically scheduled single-bank buffer with one write port
// (port_0) and one registered read port (port_1). Each port walks its own
// affine loop nest; accesses happen when the global cycle counter equals the
// port's affine schedule time.
//
// Ports:
//   clk                     in   clock
//   rst_n                   in   asynchronous active-low reset
//   flush                   in   synchronous restart of schedule state
//   config_memory_size_550  in   static config, [274:0] write, [549:275] read
//   port_0                  in   write data
//   port_1                  out  read data, valid the cycle after a read fire
//
// Build option: define LAKE_SPEC_BYPASS_EN to forward port_0 to port_1 on a
// same-cycle, same-address write and read (write-first). Without it the read
// returns the previous memory contents (read-before-write).
module lake_spec
   import lake_spec_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [CFG_WIDTH-1:0]  config_memory_size_550,
   input  logic [DATA_WIDTH-1:0] port_0,
   output logic [DATA_WIDTH-1:0] port_1
);

   port_cfg_t             wr_cfg_w, rd_cfg_w;
   logic                  wr_fire_w, rd_fire_w;
   logic [ADDR_WIDTH-1:0] wr_addr_w, rd_addr_w;
   logic [DATA_WIDTH-1:0] rd_data_w;
   logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [DATA_WIDTH-1:0] port_1_q;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   assign wr_cfg_w = unpack_port_cfg(config_memory_size_550, 1'b0);
   assign rd_cfg_w = unpack_port_cfg(config_memory_size_550, 1'b1);

   lake_spec_port_ctrl u_wr_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .cfg_i         (wr_cfg_w),
      .cycle_count_i (cycle_cnt_q),
      .fire_o        (wr_fire_w),
      .addr_o        (wr_addr_w)
   );

   lake_spec_port_ctrl u_rd_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .cfg_i         (rd_cfg_w),
      .cycle_count_i (cycle_cnt_q),
      .fire_o        (rd_fire_w),
      .addr_o        (rd_addr_w)
   );

`ifdef LAKE_SPEC_BYPASS_EN
   assign rd_data_w = (wr_fire_w && (wr_addr_w == rd_addr_w)) ? port_0 : mem_q[rd_addr_w];
`else
   assign rd_data_w = mem_q[rd_addr_w];
`endif

   assign cycle_cnt_d = flush ? '0 : cycle_cnt_q + CNT_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= '0;
         port_1_q    <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         if (rd_fire_w)
            port_1_q <= rd_data_w;
      end
   end

   // Storage has no reset; the non-blocking write makes a same-edge read
   // see the old word.
   always_ff @(posedge clk) begin
      if (wr_fire_w)
         mem_q[wr_addr_w] <= port_0;
   end

   assign port_1 = port_1_q;

endmodule

// File: tb/tb_lake_spec.sv
module tb_lake_spec;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic [549:0] cfg = '0;
   logic [15:0]  port_0 = '0;
   logic [15:0]  port_1;

   lake_spec dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .flush                  (flush),
      .config_memory_size_550 (cfg),
      .port_0                 (port_0),
      .port_1                 (port_1)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Bench-side configuration (port 0 = write, port 1 = read)
   int dim_c [2];
   int ext_c [2][6];
   int soff_c[2];
   int sstr_c[2][6];
   int aoff_c[2];
   int astr_c[2][6];

   // Reference model: each port's full access list, in iteration order
   int wt[$], wa[$], rt[$], ra[$];
   int kw, kr, mcc;
   logic [15:0] mmem [512];
   logic [15:0] exp_p1;
   logic [15:0] wdat [64];
   logic [15:0] old103;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cfg_zero();
      for (int p = 0; p < 2; p++) begin
         dim_c[p] = 1; soff_c[p] = 0; aoff_c[p] = 0;
         for (int d = 0; d < 6; d++) begin
            ext_c[p][d] = 1; sstr_c[p][d] = 0; astr_c[p][d] = 0;
         end
      end
   endtask

   function automatic logic [549:0] pack_cfg();
      logic [549:0] v;
      int b;
      v = '0;
      for (int p = 0; p < 2; p++) begin
         b = 275 * p;
         v[b +: 4]       = 4'(dim_c[p]);
         v[b + 100 +: 16] = 16'(soff_c[p]);
         v[b + 212 +: 9]  = 9'(aoff_c[p]);
         for (int d = 0; d < 6; d++) begin
            v[b + 4 + 16*d +: 16]   = 16'(ext_c[p][d]);
            v[b + 116 + 16*d +: 16] = 16'(sstr_c[p][d]);
            v[b + 221 + 9*d +: 9]   = 9'(astr_c[p][d]);
         end
      end
      return v;
   endfunction

   function automatic int eff_ext(input int p, input int d);
      return (ext_c[p][d] == 0) ? 1 : ext_c[p][d];
   endfunction

   function automatic int n_points(input int p);
      int n;
      n = 1;
      for (int d = 0; d < dim_c[p]; d++) n = n * eff_ext(p, d);
      return n;
   endfunction

   // n-th iteration of the nest (i[0] fastest) -> schedule time and address
   task automatic point(input int p, input int n, output int t, output int a);
      longint tt, aa;
      int rem, i;
      rem = n; tt = soff_c[p]; aa = aoff_c[p];
      for (int d = 0; d < dim_c[p]; d++) begin
         i   = rem % eff_ext(p, d);
         rem = rem / eff_ext(p, d);
         tt  = tt + longint'(sstr_c[p][d]) * i;
         aa  = aa + longint'(astr_c[p][d]) * i;
      end
      t = int'(tt % 65536);
      a = int'(aa % 512);
   endtask

   task automatic build_lists();
      int t, a;
      wt.delete(); wa.delete(); rt.delete(); ra.delete();
      for (int n = 0; n < n_points(0); n++) begin
         point(0, n, t, a); wt.push_back(t); wa.push_back(a);
      end
      for (int n = 0; n < n_points(1); n++) begin
         point(1, n, t, a); rt.push_back(t); ra.push_back(a);
      end
   endtask

   // One clock: drive data, let the edge happen, advance model, compare.
   task automatic step(input logic [15:0] d);
      bit wf, rf;
      port_0 = d;
      @(posedge clk);
      if (flush) begin
         mcc = 0; kw = 0; kr = 0;
      end else begin
         wf = (kw < wt.size()) && (wt[kw] == mcc);
         rf = (kr < rt.size()) && (rt[kr] == mcc);
         if (rf) begin
            exp_p1 = mmem[ra[kr]];
`ifdef LAKE_SPEC_BYPASS_EN
            if (wf && (wa[kw] == ra[kr])) exp_p1 = d;
`endif
            kr++;
         end
         if (wf) begin
            mmem[wa[kw]] = d;
            kw++;
         end
         mcc = (mcc + 1) % 65536;
      end
      #1;
      chk("port_1_model", port_1, exp_p1);
   endtask

   task automatic apply_cfg();
      cfg   = pack_cfg();
      flush = 1'b1;
      step(16'($urandom));
      flush = 1'b0;
      build_lists();
   endtask

   task automatic run_linear(input int n);
      for (int s = 0; s < n; s++) begin
         step(16'(2 * mcc));
         if (mcc >= 11 && mcc <= 74) chk("lin_data", port_1, 16'(2 * (mcc - 11)));
      end
   endtask

   task automatic set_linear();
      cfg_zero();
      ext_c[0][0] = 64; sstr_c[0][0] = 1; astr_c[0][0] = 1;
      ext_c[1][0] = 64; sstr_c[1][0] = 1; astr_c[1][0] = 1; soff_c[1] = 10;
   endtask

   initial begin
      mcc = 0; kw = 0; kr = 0; exp_p1 = '0;

      // Reset state
      cfg_zero();
      ext_c[0][0] = 512; sstr_c[0][0] = 1; astr_c[0][0] = 1;
      soff_c[1] = 60000;
      cfg = pack_cfg();
      build_lists();
      #12;
      chk("reset_state", port_1, 16'h0000);
      rst_n = 1'b1;

      // Fill every word so later reads are always defined
      for (int s = 0; s < 514; s++) step(16'($urandom));

      // Linear delay
      set_linear();
      apply_cfg();
      run_linear(80);
      chk("lin_hold", port_1, 16'd126);

      // Flush restart mid-schedule
      apply_cfg();
      run_linear(30);
      flush = 1'b1;
      for (int s = 0; s < 3; s++) step(16'($urandom));
      flush = 1'b0;
      run_linear(80);
      chk("flush_rerun_hold", port_1, 16'd126);

      // Asynchronous reset mid-schedule
      apply_cfg();
      run_linear(40);
      #2;
      rst_n = 1'b0;
      mcc = 0; kw = 0; kr = 0; exp_p1 = '0;
      #1;
      chk("reset_immediate", port_1, 16'h0000);
      port_0 = 16'hBEEF;
      @(posedge clk);
      #1;
      chk("reset_no_fire", port_1, 16'h0000);
      #2;
      rst_n = 1'b1;
      run_linear(80);
      chk("reset_rerun_hold", port_1, 16'd126);

      // 2-D transpose
      cfg_zero();
      dim_c[0] = 2; ext_c[0][0] = 4; ext_c[0][1] = 4;
      sstr_c[0][0] = 1; sstr_c[0][1] = 4; astr_c[0][0] = 1; astr_c[0][1] = 4;
      dim_c[1] = 2; ext_c[1][0] = 4; ext_c[1][1] = 4; soff_c[1] = 20;
      sstr_c[1][0] = 1; sstr_c[1][1] = 4; astr_c[1][0] = 4; astr_c[1][1] = 1;
      apply_cfg();
      for (int s = 0; s < 40; s++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if (mcc < 16) wdat[mcc] = d;
         step(d);
         if (mcc >= 21 && mcc <= 36)
            chk("transpose", port_1, wdat[((mcc - 21) % 4) * 4 + (mcc - 21) / 4]);
      end

      // Same-address collision at t = 7
      cfg_zero();
      ext_c[0][0] = 2; sstr_c[0][0] = 7; aoff_c[0] = 5;
      soff_c[1] = 7; aoff_c[1] = 5;
      apply_cfg();
      for (int s = 0; s < 12; s++) begin
         step((mcc == 0) ? 16'h00AA : (mcc == 7) ? 16'h1234 : 16'($urandom));
`ifdef LAKE_SPEC_BYPASS_EN
         if (mcc == 8) chk("collision", port_1, 16'h1234);
`else
         if (mcc == 8) chk("collision", port_1, 16'h00AA);
`endif
      end

      // Done: three writes only, the fourth word must be untouched
      cfg_zero();
      ext_c[0][0] = 3; sstr_c[0][0] = 1; aoff_c[0] = 100; astr_c[0][0] = 1;
      ext_c[1][0] = 4; sstr_c[1][0] = 1; aoff_c[1] = 100; astr_c[1][0] = 1; soff_c[1] = 20;
      old103 = mmem[103];
      apply_cfg();
      for (int s = 0; s < 30; s++) begin
         logic [15:0] d;
         d = 16'($urandom);
         if (mcc < 16) wdat[mcc] = d;
         step(d);
         if (mcc >= 21 && mcc <= 23) chk("done_written", port_1, wdat[mcc - 21]);
         if (mcc == 24) chk("done_untouched", port_1, old103);
      end

      // Randomized configurations
      for (int r = 0; r < 6; r++) begin
         cfg_zero();
         for (int p = 0; p < 2; p++) begin
            dim_c[p]  = int'($urandom_range(1, 3));
            soff_c[p] = int'($urandom_range(0, (p == 0) ? 30 : 60));
            aoff_c[p] = int'($urandom_range(0, 511));
            for (int d = 0; d < 6; d++) begin
               ext_c[p][d]  = int'($urandom_range(0, 4));
               sstr_c[p][d] = int'($urandom_range(0, 6));
               astr_c[p][d] = int'($urandom_range(0, 511));
            end
         end
         apply_cfg();
         for (int s = 0; s < 150; s++) step(16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lake_spec.md
Name: lake_spec

Overview:
- Statically scheduled single-bank buffer: one write port (port_0) and one read port (port_1).
- Each port has its own affine iteration domain, affine address map and affine cycle schedule.
- All of these come from one flat 550-bit configuration word that is held stable during operation.
- Used as the compute-graph memory primitive; the schedule is fixed entirely at configuration time (no handshakes).

Parameters:
- DATA_WIDTH, 16, word width of port_0, port_1 and memory.
- MEM_DEPTH, 512, memory words; address width 9.
- MAX_DIM, 6, maximum loop nest depth per port.
- CNT_WIDTH, 16, width of extents, schedule offset/strides and the cycle counter.
- CFG_WIDTH, 550, config width; fixed at 2 x 275.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous restart of schedule state.
- config_memory_size_550  in  550  static configuration; bits [274:0] configure the write port, bits [549:275] the read port.
- port_0  in  16  write data.
- port_1  out  16  read data, registered.

Behaviour:
- Per-port 275-bit field, LSB first:
  - dim [3:0]: valid values 1..6.
  - extent[d] [4+16d +: 16].
  - sched_offset [115:100].
  - sched_stride[d] [116+16d +: 16].
  - addr_offset [220:212].
  - addr_stride[d] [221+9d +: 9].
- Dimensions d >= dim are inactive: their iterator stays 0 and they take no part in carries. An extent of 0 is treated as 1.
- Loop variables:
  - Each port keeps iterators i[0..5]; i[0] is innermost.
  - addr = addr_offset + sum(addr_stride[d]*i[d]), mod 512.
  - time = sched_offset + sum(sched_stride[d]*i[d]), mod 2^16.
- cycle_count (16 bits):
  - Reset to 0.
  - While flush = 1 it is held at 0; otherwise it increments each edge and wraps at 2^16.
- Fire condition: a port fires in a cycle when (cycle_count == time) and the port is not done.
- On each fire:
  - Iterators advance odometer-style: innermost first, each wrapping to 0 at extent and carrying outward.
  - When the outermost active iterator wraps, the port sets done and never fires again until reset or flush.
- Write fire: mem[addr] <= port_0 at that edge.
- Read fire: port_1 <= mem[addr] at that edge, so data is valid the cycle after fire (1-cycle latency). port_1 holds its value when not firing.
- Same-cycle read and write to the same address: read returns the old contents (read-before-write).
- Reset (asynchronous, any time, including mid-schedule):
  - Clears iterators, done flags and cycle_count.
  - port_1 becomes 0.
  - Memory contents are not reset.
- flush = 1: synchronously clears iterators, done flags and cycle_count. No fires occur while flush is high. port_1 holds its value.
- Configuration changes while running give undefined results; the config may change only under reset or flush.
- A schedule time that is never reached simply stalls that port. No error is raised.

Optional Feature:
- LAKE_SPEC_BYPASS_EN defined: on a same-cycle write and read to the same address, port_1 takes port_0 (write-first forwarding).
- Undefined: old memory data is returned, as above.

Decomposition:
- Package lake_spec_pkg holds:
  - Width constants: DATA_WIDTH, ADDR_WIDTH = 9, CNT_WIDTH, MAX_DIM, PORT_CFG_WIDTH = 275.
  - A packed struct port_cfg_t matching the field layout, plus unpack helper functions.
- One sub-module, lake_spec_port_ctrl, instantiated twice.
  - Inputs: port_cfg_t, cycle_count, flush.
  - Holds the iterators and done flag.
  - Outputs: fire and addr.
- Top level holds:
  - the memory array;
  - cycle_count;
  - the port_1 register.

Test Plan:
- Linear delay, data:
  - Write port: dim=1, extent 64, sched offset 0 stride 1, addr stride 1.
  - Read port: same, but sched offset 10.
  - Stimulus: port_0 = 2*cycle_count.
  - Required: port_1 = 2*(t-11) at cycles t = 11..74; holds 126 afterwards.
- Linear delay, reset: asserting rst_n low mid-run sets port_1 to 0 immediately, and no fire occurs on the next edge.
- 2-D transpose:
  - Write: dim=2, extents 4,4, addr strides 1,4.
  - Read: addr strides 4,1, sched offset 20.
  - Required: the read order returns writes 0,4,8,12,1,5,...
- Flush restart: flush for 3 cycles mid-schedule, then release. The linear-delay schedule reruns from t = 0 with identical output values.
- Same-address collision:
  - Write and read both target addr 5 at t = 7; mem[5] previously held 0x00AA; port_0 = 0x1234.
  - Required: port_1 = 0x00AA without LAKE_SPEC_BYPASS_EN, 0x1234 with it.
- Done behaviour: extent 3, stride 1. After 3 fires, no further writes occur even though cycle_count keeps matching later values; memory is unchanged.
